usb_ep_bridge: RTL and testbench

- Endpoint-side buffer between the ISP1362 bulk-endpoint controller and the command/spectrum module `usb`.
- RX path: buffers host bulk-OUT words (commands 16'hFFFF/FFEE/FFDD/FFCC) and presents them on `usb_read_data` / `usb_read_wait` / `usb_read_en`.
- TX path: accepts `usb_write_data` / `usb_write_en` words (LSW, MSW per channel), packs them into bulk-IN packets of PKT_WORDS, and flushes short packets on idle timeout.
- In this design the `usb_read_clk` and `usb_write_clk` inputs of `usb` are tied to CLOCK_50.

---
 rtl/usb_ep_bridge_pkg.sv | 23 ++
 rtl/usb_ep_bridge_ep_fifo.sv | 67 ++++++
 rtl/usb_ep_bridge.sv | 175 +++++++++++++++++
 tb/tb_usb_ep_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ep_bridge_pkg.sv
// -----------------------------------------------------------------------------
// usb_ep_bridge_pkg
// Shared definitions for the ISP1362 endpoint bridge:
//   - host command codes seen on the bulk-OUT stream
//   - TX packetizer state encoding (one-hot)
//   - default full bulk-IN packet size in words
// -----------------------------------------------------------------------------
package usb_ep_bridge_pkg;

   localparam logic [15:0] CMD_FETCH = 16'hFFFF;
   localparam logic [15:0] CMD_START = 16'hFFEE;
   localparam logic [15:0] CMD_PAUSE = 16'hFFDD;
   localparam logic [15:0] CMD_CLEAR = 16'hFFCC;

   // 64-byte bulk-IN packet = 32 sixteen-bit words
   localparam int DEF_PKT_WORDS = 32;

   typedef enum logic [1:0] {
      TX_IDLE = 2'b01,
      TX_SEND = 2'b10
   } tx_state_e;

endpackage

// File: rtl/usb_ep_bridge_ep_fifo.sv
// -----------------------------------------------------------------------------
// ep_fifo
// Single-clock show-ahead FIFO. The head word is visible on rdata_o whenever
// the FIFO is non-empty (0 when empty); pop_i consumes it at the clock edge.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data
//   pop_i             consume head word
//   rdata_o           head word
//   count_o           occupancy, log2(DEPTH)+1 bits (full != empty)
// -----------------------------------------------------------------------------
module ep_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full, empty, push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push_i && !full;
   assign pop_ok  = pop_i && !empty;

   // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own
   always_comb begin
      wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
      rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
   end

   // Storage is not reset; mask it so an empty FIFO always shows 0
   assign rdata_o = empty ? '0 : mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/usb_ep_bridge.sv
// -----------------------------------------------------------------------------
// usb_ep_bridge
// Endpoint-side buffer between the ISP1362 bulk endpoints and the `usb`
// command/spectrum module (all on CLOCK_50).
//   RX: host bulk-OUT words -> RX FIFO -> usb_read_data/usb_read_wait/usb_read_en
//   TX: usb_write_data/usb_write_en -> TX FIFO -> bulk-IN packets of PKT_WORDS,
//       short packets flushed after FLUSH_TIMEOUT idle cycles.
// Ports:
//   CLOCK_50, rst_n                          clock, async active-low reset
//   host_rx_data/valid/ready                 bulk-OUT word stream in
//   usb_read_data/wait/en                    show-ahead read side toward `usb`
//   usb_write_data/en, usb_write_wait        write side from `usb`
//   host_tx_data/valid/last/ready            bulk-IN word stream out
// Optional build macro USB_BRIDGE_STATUS_EN adds rx_level, tx_level,
// rx_ovf, tx_ovf (sticky overflow flags).
// -----------------------------------------------------------------------------
module usb_ep_bridge
   import usb_ep_bridge_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int RX_DEPTH      = 16,
   parameter int TX_DEPTH      = 64,
   parameter int PKT_WORDS     = DEF_PKT_WORDS,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic                  CLOCK_50,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [DATA_W-1:0]     usb_read_data,
   output logic                  usb_read_wait,
   input  logic                  usb_read_en,
   input  logic [DATA_W-1:0]     usb_write_data,
   input  logic                  usb_write_en,
   output logic                  usb_write_wait,
   output logic [DATA_W-1:0]     host_tx_data,
   output logic                  host_tx_valid,
   output logic                  host_tx_last,
   input  logic                  host_tx_ready
`ifdef USB_BRIDGE_STATUS_EN
   ,
   output logic [$clog2(RX_DEPTH):0] rx_level,
   output logic [$clog2(TX_DEPTH):0] tx_level,
   output logic                      rx_ovf,
   output logic                      tx_ovf
`endif
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;
   localparam int TO_W  = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(FLUSH_TIMEOUT - 1);

   logic [RX_CW-1:0]  rx_count;
   logic [TX_CW-1:0]  tx_count, tx_cnt_nxt;
   logic [DATA_W-1:0] tx_head;
   logic              rx_full, tx_full, tx_empty;
   logic              tx_push, tx_pop;

   tx_state_e         state_q, state_d;
   logic [TX_CW-1:0]  pkt_len_q, pkt_len_d;
   logic [TO_W-1:0]   tocnt_q, tocnt_d;
   logic              wwait_q, wwait_d;

   // ---------------- RX path ----------------
   assign rx_full       = (rx_count == RX_CW'(RX_DEPTH));
   assign host_rx_ready = !rx_full;
   assign usb_read_wait = (rx_count == '0);

   ep_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .push_i  (host_rx_valid),
      .wdata_i (host_rx_data),
      .pop_i   (usb_read_en),
      .rdata_o (usb_read_data),
      .count_o (rx_count)
   );

   // ---------------- TX path ----------------
   assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign tx_push  = usb_write_en && !tx_full;

   ep_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .push_i  (usb_write_en),
      .wdata_i (usb_write_data),
      .pop_i   (tx_pop),
      .rdata_o (tx_head),
      .count_o (tx_count)
   );

   // Wait is registered from the post-cycle occupancy; raising it at DEPTH-1
   // leaves room for the one write the writer already has in flight.
   assign tx_cnt_nxt     = tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
   assign wwait_d        = (tx_cnt_nxt >= TX_CW'(TX_DEPTH - 1));
   assign usb_write_wait = wwait_q;

   always_comb begin
      state_d       = state_q;
      pkt_len_d     = pkt_len_q;
      tocnt_d       = tocnt_q;
      host_tx_valid = 1'b0;
      host_tx_last  = 1'b0;
      host_tx_data  = '0;
      tx_pop        = 1'b0;

      // Idle timer: restarts on any write attempt or empty FIFO, saturates
      if (usb_write_en || tx_empty)  tocnt_d = '0;
      else if (tocnt_q != TO_MAX)    tocnt_d = tocnt_q + TO_W'(1);

      unique case (state_q)
         TX_IDLE: begin
            if (tx_count >= TX_CW'(PKT_WORDS)) begin
               pkt_len_d = TX_CW'(PKT_WORDS);
               state_d   = TX_SEND;
            end else if (!tx_empty && tocnt_q == TO_MAX) begin
               pkt_len_d = tx_count;
               state_d   = TX_SEND;
            end
         end
         TX_SEND: begin
            host_tx_valid = 1'b1;
            host_tx_data  = tx_head;
            host_tx_last  = (pkt_len_q == TX_CW'(1));
            if (host_tx_ready) begin
               tx_pop    = 1'b1;
               pkt_len_d = pkt_len_q - TX_CW'(1);
               if (pkt_len_q == TX_CW'(1)) begin
                  state_d = TX_IDLE;
                  tocnt_d = '0;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TX_IDLE;
         pkt_len_q <= '0;
         tocnt_q   <= '0;
         wwait_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pkt_len_q <= pkt_len_d;
         tocnt_q   <= tocnt_d;
         wwait_q   <= wwait_d;
      end
   end

`ifdef USB_BRIDGE_STATUS_EN
   logic rx_ovf_q, tx_ovf_q;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
      end else begin
         if (host_rx_valid && rx_full) rx_ovf_q <= 1'b1;
         if (usb_write_en && tx_full)  tx_ovf_q <= 1'b1;
      end
   end

   assign rx_level = rx_count;
   assign tx_level = tx_count;
   assign rx_ovf   = rx_ovf_q;
   assign tx_ovf   = tx_ovf_q;
`endif

endmodule

// File: tb/tb_usb_ep_bridge.sv
// -----------------------------------------------------------------------------
// tb_usb_ep_bridge
// Directed bench for usb_ep_bridge: table-driven RX handshake vectors plus
// hand-written sequences for RX fill, full TX packet, idle-timeout flush,
// write back-pressure and mid-packet reset.
// -----------------------------------------------------------------------------
module tb_usb_ep_bridge;

   logic        CLOCK_50 = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] host_rx_data = '0;
   logic        host_rx_valid = 1'b0;
   logic        host_rx_ready;
   logic [15:0] usb_read_data;
   logic        usb_read_wait;
   logic        usb_read_en = 1'b0;
   logic [15:0] usb_write_data = '0;
   logic        usb_write_en = 1'b0;
   logic        usb_write_wait;
   logic [15:0] host_tx_data;
   logic        host_tx_valid;
   logic        host_tx_last;
   logic        host_tx_ready = 1'b0;
`ifdef USB_BRIDGE_STATUS_EN
   logic [4:0]  rx_level;
   logic [6:0]  tx_level;
   logic        rx_ovf, tx_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   usb_ep_bridge dut (
      .CLOCK_50       (CLOCK_50),
      .rst_n          (rst_n),
      .host_rx_data   (host_rx_data),
      .host_rx_valid  (host_rx_valid),
      .host_rx_ready  (host_rx_ready),
      .usb_read_data  (usb_read_data),
      .usb_read_wait  (usb_read_wait),
      .usb_read_en    (usb_read_en),
      .usb_write_data (usb_write_data),
      .usb_write_en   (usb_write_en),
      .usb_write_wait (usb_write_wait),
      .host_tx_data   (host_tx_data),
      .host_tx_valid  (host_tx_valid),
      .host_tx_last   (host_tx_last),
      .host_tx_ready  (host_tx_ready)
`ifdef USB_BRIDGE_STATUS_EN
      ,
      .rx_level       (rx_level),
      .tx_level       (tx_level),
      .rx_ovf         (rx_ovf),
      .tx_ovf         (tx_ovf)
`endif
   );

   typedef struct {
      logic        vld;
      logic [15:0] din;
      logic        ren;
      logic        exp_rdy;
      logic        exp_wait;
      logic [15:0] exp_dout;
   } rx_vec_t;

   rx_vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drains one bulk-IN packet of n words starting at value base
   task automatic collect(input string name, input logic [15:0] base, input int n);
      int beats = 0;
      int cyc   = 0;
      host_tx_ready = 1'b1;
      while (beats < n && cyc < 2000) begin
         if (host_tx_valid) begin
            check({name, "_data"}, 32'(host_tx_data), 32'(base + 16'(beats)));
            check({name, "_last"}, 32'(host_tx_last), 32'(beats == n - 1));
            beats++;
         end
         @(negedge CLOCK_50);
         cyc++;
      end
      host_tx_ready = 1'b0;
      check({name, "_beats"}, 32'(beats), 32'(n));
   endtask

   initial begin
      int waited;
      int writes;
      int occ_at_wait;
      int stale;
      logic last_w, cur_w, en;

      // Rows: {valid, data, read_en, exp ready, exp wait, exp head}
      // Expectations reflect state before this row's clock edge.
      vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[1]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF};
      vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF};
      vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000};
      vecs[6]  = '{1'b1, 16'hFFEE, 1'b0, 1'b1, 1'b1, 16'h0000};
      vecs[7]  = '{1'b1, 16'hFFDD, 1'b0, 1'b1, 1'b0, 16'hFFEE};
      vecs[8]  = '{1'b1, 16'hFFCC, 1'b1, 1'b1, 1'b0, 16'hFFEE};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFDD};
      vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFCC};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};

      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      rst_n = 1'b1;

      check("rst_tx_valid", 32'(host_tx_valid), 32'd0);
      check("rst_tx_last", 32'(host_tx_last), 32'd0);
      check("rst_tx_data", 32'(host_tx_data), 32'd0);
      check("rst_write_wait", 32'(usb_write_wait), 32'd0);

      // ---------------- RX handshake vectors ----------------
      @(posedge CLOCK_50); #1;
      for (int i = 0; i < 12; i++) begin
         host_rx_valid = vecs[i].vld;
         host_rx_data  = vecs[i].din;
         usb_read_en   = vecs[i].ren;
         @(negedge CLOCK_50);
         check($sformatf("vec%0d_ready", i), 32'(host_rx_ready), 32'(vecs[i].exp_rdy));
         check($sformatf("vec%0d_wait", i), 32'(usb_read_wait), 32'(vecs[i].exp_wait));
         check($sformatf("vec%0d_data", i), 32'(usb_read_data), 32'(vecs[i].exp_dout));
         @(posedge CLOCK_50); #1;
      end
      host_rx_valid = 1'b0;
      usb_read_en   = 1'b0;

      // ---------------- RX fill to full, 17th word refused ----------------
      for (int i = 0; i < 16; i++) begin
         host_rx_valid = 1'b1;
         host_rx_data  = 16'h1000 + 16'(i);
         @(posedge CLOCK_50); #1;
      end
      host_rx_valid = 1'b0;
      check("rx_full_ready", 32'(host_rx_ready), 32'd0);
      host_rx_valid = 1'b1;
      host_rx_data  = 16'hBEEF;
      @(posedge CLOCK_50); #1;
      host_rx_valid = 1'b0;
      check("rx_full_ready_hold", 32'(host_rx_ready), 32'd0);
`ifdef USB_BRIDGE_STATUS_EN
      check("rx_ovf", 32'(rx_ovf), 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         check($sformatf("rx_drain%0d", i), 32'(usb_read_data), 32'(16'h1000 + 16'(i)));
         usb_read_en = 1'b1;
         @(posedge CLOCK_50); #1;
      end
      usb_read_en = 1'b0;
      check("rx_drained_wait", 32'(usb_read_wait), 32'd1);
      check("rx_drained_ready", 32'(host_rx_ready), 32'd1);

      // ---------------- full 32-word packet ----------------
      for (int i = 0; i < 32; i++) begin
         usb_write_en   = 1'b1;
         usb_write_data = 16'hA000 + 16'(i);
         @(posedge CLOCK_50); #1;
      end
      usb_write_en = 1'b0;
      collect("pkt32", 16'hA000, 32);
      check("pkt32_gap_valid", 32'(host_tx_valid), 32'd0);

      // ---------------- short packet flushed on timeout ----------------
      for (int i = 0; i < 5; i++) begin
         usb_write_en   = 1'b1;
         usb_write_data = 16'hB000 + 16'(i);
         @(posedge CLOCK_50); #1;
      end
      usb_write_en = 1'b0;
      waited = 0;
      while (!host_tx_valid && waited < 1100) begin
         @(posedge CLOCK_50);
         waited++;
         @(negedge CLOCK_50);
      end
      check("flush_latency", 32'(waited), 32'd1024);
      collect("pkt5", 16'hB000, 5);
      check("pkt5_after_valid", 32'(host_tx_valid), 32'd0);

      // ---------------- back-pressure with one-cycle-late writer ----------------
      @(posedge CLOCK_50); #1;
      writes = 0;
      occ_at_wait = -1;
      last_w = usb_write_wait;
      for (int c = 0; c < 80; c++) begin
         @(posedge CLOCK_50); #1;
         en    = !last_w;
         cur_w = usb_write_wait;
         if (cur_w && occ_at_wait < 0) occ_at_wait = writes;
         usb_write_en   = en;
         usb_write_data = 16'hD000 + 16'(writes);
         if (en) writes++;
         last_w = cur_w;
      end
      @(posedge CLOCK_50); #1;
      usb_write_en = 1'b0;
      check("bp_wait_occ", 32'(occ_at_wait), 32'd63);
      check("bp_writes", 32'(writes), 32'd64);
      check("bp_wait_high", 32'(usb_write_wait), 32'd1);
`ifdef USB_BRIDGE_STATUS_EN
      check("bp_tx_ovf", 32'(tx_ovf), 32'd0);
      check("bp_tx_level", 32'(tx_level), 32'd64);
`endif
      @(negedge CLOCK_50);
      collect("bp_pkt0", 16'hD000, 32);
      check("bp_gap_valid", 32'(host_tx_valid), 32'd0);
      collect("bp_pkt1", 16'hD020, 32);
      check("bp_wait_low", 32'(usb_write_wait), 32'd0);

      // ---------------- reset mid-packet ----------------
      host_rx_valid = 1'b1;
      host_rx_data  = 16'hFFDD;
      @(posedge CLOCK_50); #1;
      host_rx_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         usb_write_en   = 1'b1;
         usb_write_data = 16'hE000 + 16'(i);
         @(posedge CLOCK_50); #1;
      end
      usb_write_en = 1'b0;
      @(posedge CLOCK_50); #1;
      check("mid_valid_pre", 32'(host_tx_valid), 32'd1);
      check("mid_read_wait_pre", 32'(usb_read_wait), 32'd0);
      host_tx_ready = 1'b1;
      @(posedge CLOCK_50); #1;
      @(posedge CLOCK_50); #2;
      rst_n = 1'b0;
      #1;
      check("arst_tx_valid", 32'(host_tx_valid), 32'd0);
      check("arst_tx_last", 32'(host_tx_last), 32'd0);
      check("arst_tx_data", 32'(host_tx_data), 32'd0);
      check("arst_write_wait", 32'(usb_write_wait), 32'd0);
      check("arst_read_wait", 32'(usb_read_wait), 32'd1);
      check("arst_read_data", 32'(usb_read_data), 32'd0);
      check("arst_rx_ready", 32'(host_rx_ready), 32'd1);
      host_tx_ready = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      rst_n = 1'b1;
      host_tx_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 1200; c++) begin
         @(negedge CLOCK_50);
         if (host_tx_valid) stale++;
      end
      host_tx_ready = 1'b0;
      check("post_rst_stale_beats", 32'(stale), 32'd0);
      check("post_rst_read_wait", 32'(usb_read_wait), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
